switch_pipe: RTL and testbench
==============================

// Module: switch_pipe
// PURPOSE
//  Parametrised, pipelined successor of the combinational a^b switch: WIDTH-bit bitwise unit
//  with op select (XOR/XNOR/AND/OR) and a multi-beat XOR-accumulate mode.
//  Valid/ready on both sides; registered output with a skid buffer so in_ready is a flop.
//  Sits between a stimulus/producer stage and any backpressuring consumer in the demo datapath.
// PARAMETERS
//  WIDTH   8    operand/result width in bits (>=1)
//  CNT_W   16   width of the accepted-beat counter (saturating)
// PORTS
//  clk         in   1      single clock, all state on posedge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      input beat valid
//  in_ready    out  1      input beat accepted when in_valid && in_ready
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  in_op       in   3      0 XOR, 1 XNOR, 2 AND, 3 OR, 4 ACC, 5-7 reserved
//  in_last     in   1      ACC only: final beat of accumulation
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer takes result when out_valid && out_ready
//  out_f       out  WIDTH  result
//  out_parity  out  1      ^out_f, coherent with out_f
//  beat_cnt    out  CNT_W  accepted input beats, saturates at all-ones
//  err         out  1      sticky: reserved op seen or ACC aborted; cleared only by reset
// BEHAVIOUR
//  - Reset (async assert, sync release): in_ready=1 (held 0 while rst_n low is NOT required;
//    in_ready=1 from first post-reset cycle), out_valid=0, out_f=0, out_parity=0,
//    beat_cnt=0, err=0, acc=0, FSM=IDLE, skid empty.
//  - Latency: accepted non-accumulating beat -> out_valid next cycle if output reg free.
//  - Output reg + 1-entry skid: in_ready = !skid_valid (registered). out_valid && !out_ready
//    holds out_f/out_parity stable; a beat arriving that cycle lands in skid; skid drains to
//    output reg on next out_ready. No beat dropped or duplicated; order preserved.
//  - Ops 0-3: out_f = a^b, ~(a^b), a&b, a|b. Reserved 5-7: compute as XOR and set err.
//  - ACC FSM (states IDLE, ACCUM):
//    IDLE, op=ACC, !last -> acc=a^b, no output, -> ACCUM.
//    IDLE, op=ACC, last  -> emit a^b (single-beat accumulate), stay IDLE.
//    ACCUM, op=ACC, !last -> acc^=a^b, no output, stay ACCUM.
//    ACCUM, op=ACC, last -> emit acc^a^b, acc=0, -> IDLE.
//    ACCUM, op!=ACC -> abort: err=1, acc=0, -> IDLE; that beat processed normally and emitted.
//    in_last ignored for ops != ACC.
//  - Non-emitting ACC beats never consume output/skid space but still need in_ready=1.
//  - beat_cnt increments on every accepted beat (emitting or not); saturates, no wrap.
//  - Simultaneous out handshake and in accept with full output reg: fresh result
//    goes directly to output reg if skid empty, else skid moves up and new beat fills skid.
//  - Reset mid-accumulation discards acc and any pending outputs.
// STRUCTURE
//  - Package switch_pkg: op_e enum (OP_XOR..OP_ACC), acc_state_e {IDLE, ACCUM}, OP_W=3.
//  - Sub-module switch_skid (WIDTH+1 payload: {parity,f}) owns output reg + skid + ready.
//  - Top: op decode, accumulator FSM, beat counter, err flag.
// TESTING (WIDTH=8)
//  1 out_ready=1; ops 0-3 on a=8'hA5,b=8'h0F -> 8'hAA/8'h55/8'h05/8'hAF, parity 0/0/0/0, 1 cyc.
//  2 ACC beats (a^b)=8'h01,8'h02,8'h04(last) -> one result 8'h07, parity 1; beat_cnt=3.
//  3 out_ready=0 for 5 cycles, stream 4 XOR beats -> 2 accepted, in_ready=0, then all 4 in order.
//  4 ACC 8'h3C (no last) then XOR a=8'h01,b=8'h00 -> err=1, sole output 8'h01, FSM IDLE.
//  5 in_op=6, a=8'hF0,b=8'h0F -> out_f=8'hFF, err=1, err stays 1 after later valid ops.
//  6 rst_n low mid-ACC with output stalled -> out_valid=0, beat_cnt=0, next ACC last emits a^b only.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types for the pipelined bitwise switch: op encoding and accumulator FSM states.
package switch_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_XOR  = 3'd0,
        OP_XNOR = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_ACC  = 3'd4
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

endpackage

// File: rtl/switch_skid.sv
// Output register plus one-entry skid buffer; o_ready is the inverse of the skid-full flop.
// Handshake: a beat moves on a side when its valid and ready are both high at posedge clk.
module switch_skid #(
    parameter int PW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [PW-1:0] i_data,
    output logic          o_ready,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [PW-1:0] o_data
);

    logic          r_out_valid;
    logic [PW-1:0] r_out_data;
    logic          r_skid_valid;
    logic [PW-1:0] r_skid_data;
    logic          w_out_free;

    assign w_out_free = !r_out_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Skid is older than any new beat, so it moves up first.
                r_out_valid <= 1'b1;
                r_out_data  <= r_skid_data;
                if (i_push) begin
                    r_skid_data <= i_data;
                end else begin
                    r_skid_valid <= 1'b0;
                end
            end else if (i_push) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_data;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (i_push) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
        end
    end

    assign o_ready = !r_skid_valid;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

// File: rtl/switch_pipe.sv
// Pipelined bitwise switch: op decode, XOR-accumulate FSM, saturating beat counter, sticky error.
// Handshake: a beat moves on a side when its valid and ready are both high at posedge clk.
module switch_pipe
    import switch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_parity,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             err,
    output logic             dbg_state
);

    acc_state_e       r_state;
    acc_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_accept;
    logic             w_emit;
    logic             w_set_err;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH:0]   w_out_data;
    op_e              w_op;

    assign w_op     = op_e'(in_op);
    assign w_x      = in_a ^ in_b;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_emit      = 1'b0;
        w_set_err   = 1'b0;
        w_result    = w_x;
        if (w_accept) begin
            if (w_op == OP_ACC) begin
                if (in_last) begin
                    w_emit      = 1'b1;
                    w_result    = (r_state == ACCUM) ? (r_acc ^ w_x) : w_x;
                    w_acc_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_acc_nxt   = (r_state == ACCUM) ? (r_acc ^ w_x) : w_x;
                    w_state_nxt = ACCUM;
                end
            end else begin
                w_emit = 1'b1;
                case (w_op)
                    OP_XNOR: w_result = ~w_x;
                    OP_AND:  w_result = in_a & in_b;
                    OP_OR:   w_result = in_a | in_b;
                    OP_XOR:  w_result = w_x;
                    default: begin
                        w_result  = w_x;
                        w_set_err = 1'b1;
                    end
                endcase
                // A non-ACC beat during accumulation aborts it but is still processed.
                if (r_state == ACCUM) begin
                    w_set_err   = 1'b1;
                    w_acc_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    switch_skid #(.PW(WIDTH + 1)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_emit),
        .i_data  ({^w_result, w_result}),
        .o_ready (in_ready),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_data)
    );

    assign out_f      = w_out_data[WIDTH-1:0];
    assign out_parity = w_out_data[WIDTH];
    assign beat_cnt   = r_cnt;
    assign err        = r_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_switch_pipe.sv
// Self-checking bench for switch_pipe (WIDTH=8): directed scenarios plus a randomized backpressure run.
module tb_switch_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [2:0]  in_op;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_f;
    logic        out_parity;
    logic [15:0] beat_cnt;
    logic        err;
    logic        dbg_state;

    logic [8:0]  exp_q[$];
    int          n_cmp;
    int          n_err;
    int          n_acc;
    bit          rnd_done;

    logic        m_state;
    logic [7:0]  m_acc;
    logic        m_err;
    logic [15:0] m_cnt;

    logic [7:0]  t1_exp [4];

    switch_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_f      (out_f),
        .out_parity (out_parity),
        .beat_cnt   (beat_cnt),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_state = 1'b0;
        m_acc   = 8'h00;
        m_err   = 1'b0;
        m_cnt   = 16'h0;
    endtask

    task automatic model_beat(input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] op, input logic last);
        logic [7:0] f;
        logic       emit;
        emit = 1'b0;
        case (op)
            3'd1:    f = ~(a ^ b);
            3'd2:    f = a & b;
            3'd3:    f = a | b;
            default: f = a ^ b;
        endcase
        if (op == 3'd4) begin
            if (last) begin
                emit    = 1'b1;
                f       = m_state ? (m_acc ^ a ^ b) : (a ^ b);
                m_acc   = 8'h00;
                m_state = 1'b0;
            end else begin
                m_acc   = m_state ? (m_acc ^ a ^ b) : (a ^ b);
                m_state = 1'b1;
            end
        end else begin
            emit = 1'b1;
            if (op > 3'd4) m_err = 1'b1;
            if (m_state) begin
                m_err   = 1'b1;
                m_acc   = 8'h00;
                m_state = 1'b0;
            end
        end
        if (m_cnt != 16'hFFFF) m_cnt++;
        if (emit) exp_q.push_back({^f, f});
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic last);
        int  waited;
        bit  ok;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_last  = last;
        in_valid = 1'b1;
        ok       = 1'b0;
        waited   = 0;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (in_ready) begin
                model_beat(a, b, op, last);
                n_acc++;
                ok = 1'b1;
            end
            waited++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            chk("send_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard: every output handshake pops the oldest expected result.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {24'h0, out_f}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_f", {24'h0, out_f}, {24'h0, e[7:0]});
                chk("out_parity", {31'h0, out_parity}, {31'h0, e[8]});
            end
        end
    end

    initial begin
        int base;
        n_cmp     = 0;
        n_err     = 0;
        n_acc     = 0;
        rnd_done  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_op     = 3'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        t1_exp    = '{8'hAA, 8'h55, 8'h05, 8'hAF};
        do_reset();

        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_f", {24'h0, out_f}, 32'd0);
        chk("rst_out_parity", {31'h0, out_parity}, 32'd0);
        chk("rst_beat_cnt", {16'h0, beat_cnt}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_state", {31'h0, dbg_state}, 32'd0);

        // Ops 0-3, one-cycle latency with consumer ready.
        for (int i = 0; i < 4; i++) begin
            send(8'hA5, 8'h0F, i[2:0], 1'b0);
            chk("t1_valid", {31'h0, out_valid}, 32'd1);
            chk("t1_f", {24'h0, out_f}, {24'h0, t1_exp[i]});
            chk("t1_parity", {31'h0, out_parity}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Three-beat accumulate: 01 ^ 02 ^ 04.
        send(8'h00, 8'h01, 3'd4, 1'b0);
        chk("t2_no_out0", {31'h0, out_valid}, 32'd0);
        chk("t2_state", {31'h0, dbg_state}, 32'd1);
        send(8'h03, 8'h01, 3'd4, 1'b0);
        chk("t2_no_out1", {31'h0, out_valid}, 32'd0);
        send(8'h0C, 8'h08, 3'd4, 1'b1);
        chk("t2_valid", {31'h0, out_valid}, 32'd1);
        chk("t2_f", {24'h0, out_f}, 32'h07);
        chk("t2_parity", {31'h0, out_parity}, 32'd1);
        chk("t2_beat_cnt", {16'h0, beat_cnt}, 32'd7);
        chk("t2_state_idle", {31'h0, dbg_state}, 32'd0);

        // Stall the consumer while four beats are offered.
        @(posedge clk);
        #1 out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 4; i++) send(8'h10 + i[7:0], 8'h01, 3'd0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                chk("t3_in_ready", {31'h0, in_ready}, 32'd0);
                chk("t3_accepted", n_acc - base, 32'd2);
                chk("t3_held_f", {24'h0, out_f}, 32'h11);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("t3_drained", exp_q.size(), 32'd0);

        // Abort an accumulation with a plain XOR.
        chk("t4_err_before", {31'h0, err}, 32'd0);
        send(8'h3C, 8'h00, 3'd4, 1'b0);
        send(8'h01, 8'h00, 3'd0, 1'b0);
        chk("t4_f", {24'h0, out_f}, 32'h01);
        chk("t4_err", {31'h0, err}, 32'd1);
        chk("t4_state", {31'h0, dbg_state}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reserved op computes XOR and sets a sticky error.
        do_reset();
        chk("t5_err_cleared", {31'h0, err}, 32'd0);
        send(8'hF0, 8'h0F, 3'd6, 1'b0);
        chk("t5_f", {24'h0, out_f}, 32'hFF);
        chk("t5_err", {31'h0, err}, 32'd1);
        send(8'h12, 8'h34, 3'd3, 1'b0);
        send(8'h12, 8'h34, 3'd4, 1'b1);
        chk("t5_err_sticky", {31'h0, err}, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Reset while accumulating with an output stalled.
        out_ready = 1'b0;
        send(8'h55, 8'h00, 3'd0, 1'b0);
        send(8'h0F, 8'h00, 3'd4, 1'b0);
        chk("t6_pending", {31'h0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", {31'h0, out_valid}, 32'd0);
        chk("t6_beat_cnt", {16'h0, beat_cnt}, 32'd0);
        chk("t6_state", {31'h0, dbg_state}, 32'd0);
        model_clear();
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h11, 8'h22, 3'd4, 1'b1);
        chk("t6_f", {24'h0, out_f}, 32'h33);
        repeat (2) @(posedge clk);
        #1;

        // Random traffic against random backpressure.
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("end_queue_empty", exp_q.size(), 32'd0);
        chk("end_beat_cnt", {16'h0, beat_cnt}, {16'h0, m_cnt});
        chk("end_err", {31'h0, err}, {31'h0, m_err});
        chk("end_state", {31'h0, dbg_state}, {31'h0, m_state});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
